// File: rtl/traffic_phase_sequencer.sv
// Two-road traffic light sequencer with pedestrian walk and emergency all-red.
// Lamp, walk and phase outputs come straight from flops; no input reaches them combinationally.
module traffic_phase_sequencer #(
  parameter int TICK_DIV = 4,
  parameter int GREEN_T  = 8,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 2,
  parameter int WALK_T   = 5,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ped_req,
  input  logic             emerg,
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic             walk,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] remain
);

  typedef enum logic [2:0] {
    NS_G = 3'd0,
    NS_Y = 3'd1,
    AR1  = 3'd2,
    EW_G = 3'd3,
    EW_Y = 3'd4,
    AR2  = 3'd5,
    EMG  = 3'd6,
    BAD  = 3'd7
  } state_t;

  localparam int PW = $clog2(TICK_DIV);

  localparam logic [CNT_W-1:0] GREEN_R  = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] YELLOW_R = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_R = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] WALK_R   = CNT_W'(WALK_T - 1);
  localparam logic [PW-1:0]    PRE_MAX  = PW'(TICK_DIV - 1);

  localparam logic [2:0] L_R = 3'b100;
  localparam logic [2:0] L_Y = 3'b010;
  localparam logic [2:0] L_G = 3'b001;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             ped_pend_q, ped_pend_d;
  logic             walk_act_q, walk_act_d;
  logic [2:0]       ns_q, ns_d;
  logic [2:0]       ew_q, ew_d;
  logic             walk_q, walk_d;
  logic             tick;

  always_comb begin
    state_d    = state_q;
    remain_d   = remain_q;
    presc_d    = presc_q;
    ped_pend_d = ped_pend_q | ped_req;
    walk_act_d = walk_act_q;
    tick       = en && (presc_q == PRE_MAX);

    if (emerg) begin
      state_d    = EMG;
      remain_d   = '0;
      presc_d    = '0;
      walk_act_d = 1'b0;
    end else if (state_q == EMG) begin
      state_d    = AR2;
      remain_d   = ALLRED_R;
      presc_d    = '0;
      walk_act_d = 1'b0;
    end else if (state_q == BAD) begin
      state_d    = NS_G;
      remain_d   = GREEN_R;
      presc_d    = '0;
      walk_act_d = 1'b0;
    end else begin
      if (en) presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        if (remain_q != '0) begin
          remain_d = remain_q - CNT_W'(1);
        end else begin
          walk_act_d = 1'b0;
          case (state_q)
            NS_G:    begin state_d = NS_Y; remain_d = YELLOW_R; end
            NS_Y:    begin state_d = AR1;  remain_d = ALLRED_R; end
            AR1:     begin state_d = EW_G; remain_d = GREEN_R;  end
            EW_G:    begin state_d = EW_Y; remain_d = YELLOW_R; end
            EW_Y:    begin state_d = AR2;  remain_d = ALLRED_R; end
            default: begin state_d = NS_G; remain_d = GREEN_R;  end
          endcase
          // A pending request stretches the all-red; a same-cycle press re-arms it.
          if ((state_d == AR1 || state_d == AR2) && ped_pend_q) begin
            remain_d   = WALK_R;
            walk_act_d = 1'b1;
            ped_pend_d = ped_req;
          end
        end
      end
    end

    case (state_d)
      NS_G:    begin ns_d = L_G; ew_d = L_R; end
      NS_Y:    begin ns_d = L_Y; ew_d = L_R; end
      EW_G:    begin ns_d = L_R; ew_d = L_G; end
      EW_Y:    begin ns_d = L_R; ew_d = L_Y; end
      default: begin ns_d = L_R; ew_d = L_R; end
    endcase
    walk_d = walk_act_d && (state_d == AR1 || state_d == AR2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= NS_G;
      remain_q   <= GREEN_R;
      presc_q    <= '0;
      ped_pend_q <= 1'b0;
      walk_act_q <= 1'b0;
      ns_q       <= L_G;
      ew_q       <= L_R;
      walk_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      remain_q   <= remain_d;
      presc_q    <= presc_d;
      ped_pend_q <= ped_pend_d;
      walk_act_q <= walk_act_d;
      ns_q       <= ns_d;
      ew_q       <= ew_d;
      walk_q     <= walk_d;
    end
  end

  assign ns_light = ns_q;
  assign ew_light = ew_q;
  assign walk     = walk_q;
  assign phase    = state_q;
  assign remain   = remain_q;

endmodule

// File: doc/traffic_phase_sequencer.md
Name: traffic_phase_sequencer

Overview:
- Consumes the free-running `clk` from the clock generator and turns it into a timed two-road traffic-light sequence.
- Sequence: NS green/yellow, all-red, EW green/yellow, all-red.
- Supports a pedestrian walk interval and an emergency all-red override.
- Sits between the clock source and the lamp drivers/display; reports current phase and remaining seconds.

Parameters:
- TICK_DIV, 4, clk cycles per one-second tick (>=2)
- GREEN_T, 8, green duration in ticks (>=1)
- YELLOW_T, 3, yellow duration in ticks (>=1)
- ALLRED_T, 2, all-red duration in ticks (>=1)
- WALK_T, 5, all-red duration in ticks when a pedestrian request is pending (>=1)
- CNT_W, 8, width of remain counter; must hold max(all durations)-1

Ports:
- clk, input, 1, system clock from clock generator
- rst, input, 1, asynchronous active-high reset
- en, input, 1, run enable; 0 freezes prescaler and sequence
- ped_req, input, 1, pedestrian button, level or pulse, sampled every clk
- emerg, input, 1, emergency override, level
- ns_light, output, 3, NS lamps one-hot {red,yellow,green}
- ew_light, output, 3, EW lamps one-hot {red,yellow,green}
- walk, output, 1, pedestrian walk lamp
- phase, output, 3, state code
- remain, output, CNT_W, ticks left in current phase minus one

Behaviour:
- Interface: one clock `clk`. Reset `rst` is asynchronous, active-high. All state is registered on posedge `clk`.
- Reset values:
  - state=NS_G, remain=GREEN_T-1, prescaler=0, ped_pend=0, tick=0
  - ns_light=3'b001, ew_light=3'b100, walk=0, phase=0
- Prescaler:
  - When en=1: counts 0..TICK_DIV-1, then wraps to 0.
  - tick=1 for exactly the one cycle where prescaler==TICK_DIV-1 and en=1.
  - When en=0: prescaler holds and tick=0.
- Phase codes: NS_G=0, NS_Y=1, AR1=2, EW_G=3, EW_Y=4, AR2=5, EMG=6. Code 7 is unused; if reached, go to NS_G next cycle.
- Lamps by state:
  - NS_G: ns=G, ew=R
  - NS_Y: ns=Y, ew=R
  - EW_G: ns=R, ew=G
  - EW_Y: ns=R, ew=Y
  - AR1, AR2, EMG: both R
  - Lamps, walk and phase are decoded from registered state only (no input-to-output combinational path).
- Timing:
  - On a tick with remain>0: remain decrements.
  - On a tick with remain==0: advance to the next state and load remain with that state's duration-1.
  - Order: NS_G->NS_Y->AR1->EW_G->EW_Y->AR2->NS_G.
  - Each phase lasts exactly duration*TICK_DIV enabled cycles.
- Pedestrian handling:
  - ped_req=1 in any cycle sets ped_pend.
  - On entry to AR1 or AR2 with ped_pend=1: load WALK_T-1 instead of ALLRED_T-1, set walk_act, clear ped_pend in the same cycle.
  - walk=1 while walk_act=1 in AR1/AR2; walk_act clears on leaving the state.
  - A ped_req arriving during walk re-sets ped_pend and is served at the next all-red.
  - Simultaneous entry-clear and new ped_req: set wins.
- Emergency handling:
  - emerg=1 (sampled, en-independent) moves state to EMG on the next clk edge from any state.
  - Entry to EMG: prescaler cleared, remain=0, walk_act=0; ped_pend retained.
  - While emerg=1: stay in EMG.
  - When emerg falls to 0: go to AR2 with remain=ALLRED_T-1 and prescaler=0, regardless of ped_pend; normal sequence resumes after AR2.
  - Priority: rst > emerg > tick advance > ped.
- Reset mid-phase: all state returns to reset values immediately (asynchronous). The sequence restarts at full NS_G on the first clk after rst deasserts.

Test Plan:
- Defaults, en=1 after reset:
  - NS_G for 32 clk, then NS_Y 12, AR1 8, EW_G 32, EW_Y 12, AR2 8; full period 104 clk.
  - remain shows 7..0 in NS_G, changing every 4 clk.
- Pulse ped_req 1 clk during NS_G:
  - AR1 lasts 20 clk with walk=1.
  - Following AR2 lasts 8 clk with walk=0.
- Raise emerg mid-EW_G with remain=4:
  - Next edge: phase=6, both lamps R.
  - Hold 10 clk, drop emerg: AR2 for 8 clk, then NS_G for 32 clk.
- en=0 for 15 clk mid NS_Y:
  - remain and prescaler frozen, lamps unchanged.
  - After en=1, phase completes with the exact remaining cycle count.
- Assert rst asynchronously mid AR1 with ped_pend=1:
  - Outputs return to reset values before the next clk edge; ped_pend=0.
  - The next AR1 is 8 clk.
- ped_req held high across AR1 entry:
  - Walk is served in AR1 and ped_pend re-sets.
  - AR2 also lasts 20 clk with walk=1.
